// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter slice.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        SZ_WORD     = 2'b00,
        SZ_BYTE     = 2'b01,
        SZ_HALF     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } m_size_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_M = 1'b1
    } port_e;

    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requesters, regfile write port and decode scoreboard signals.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;

    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_size;

    logic                  wr_hold;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_mask;

    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              rs_busy;
    logic              rt_busy;

    modport slave (
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  m_valid, m_addr, m_data, m_size,
        output m_ready,
        input  wr_hold,
        output wr_en, wr_addr, wr_data, wr_mask,
        input  sb_set, sb_addr, rs, rt,
        output rs_busy, rt_busy
    );

    modport master (
        output a_valid, a_addr, a_data,
        input  a_ready,
        output m_valid, m_addr, m_data, m_size,
        input  m_ready,
        output wr_hold,
        input  wr_en, wr_addr, wr_data, wr_mask,
        output sb_set, sb_addr, rs, rt,
        input  rs_busy, rt_busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              rs_busy,
    output logic              rt_busy
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    // Set is applied after clear so a newer producer keeps the register busy.
    always_comb begin
        pending_next = pending;
        if (clr_en) begin
            pending_next[clr_addr] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            pending_next[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign rs_busy = pending[rs];
    assign rt_busy = pending[rt];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load writeback.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int MASK_W = DATA_W / 8;

    port_e rr_last;
    port_e rr_next;
    logic  grant_a;
    logic  grant_m;

    logic              vld_p0;
    logic              xfer_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic [MASK_W-1:0] mask_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic [MASK_W-1:0] mask_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= PORT_M;
        end else begin
            rr_last <= rr_next;
        end
    end

    always_comb begin
        rr_next = rr_last;
        if (grant_a) begin
            rr_next = PORT_A;
        end else if (grant_m) begin
            rr_next = PORT_M;
        end
    end

    // On contention the port granted last yields.
    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (!bus.wr_hold) begin
            grant_a = bus.a_valid && (!bus.m_valid || (rr_last == PORT_M));
            grant_m = bus.m_valid && (!bus.a_valid || (rr_last == PORT_A));
        end
    end

    assign bus.a_ready = grant_a;
    assign bus.m_ready = grant_m;

    // ---- stage p0: select the granted request and decode its byte mask
    always_comb begin
        addr_p0 = bus.a_addr;
        data_p0 = bus.a_data;
        mask_p0 = '1;
        if (grant_m) begin
            addr_p0 = bus.m_addr;
            data_p0 = bus.m_data;
            case (m_size_e'(bus.m_size))
                SZ_BYTE: mask_p0 = MASK_W'(MASK_BYTE);
                SZ_HALF: mask_p0 = MASK_W'(MASK_HALF);
                default: mask_p0 = '1;
            endcase
        end
    end

    assign xfer_p0 = grant_a || grant_m;
    assign vld_p0  = xfer_p0 && (addr_p0 != '0);

    // ---- stage p1: registered regfile write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            mask_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (xfer_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
                mask_p1 <= mask_p0;
            end
        end
    end

    assign bus.wr_en   = vld_p1;
    assign bus.wr_addr = addr_p1;
    assign bus.wr_data = data_p1;
    assign bus.wr_mask = mask_p1;

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .sb_set   (bus.sb_set),
        .sb_addr  (bus.sb_addr),
        .clr_en   (vld_p1),
        .clr_addr (addr_p1),
        .rs       (bus.rs),
        .rt       (bus.rt),
        .rs_busy  (bus.rs_busy),
        .rt_busy  (bus.rt_busy)
    );

endmodule
